// File: rtl/mips_multicycle_control_if.sv
// Memory handshake between the multicycle control FSM and the shared
// instruction/data memory: address select, read/write requests and completion.
interface mips_multicycle_control_if;
  logic IorD;
  logic MemRead;
  logic MemWrite;
  logic MemReady;

  modport master (output IorD, output MemRead, output MemWrite, input MemReady);
  modport slave  (input IorD, input MemRead, input MemWrite, output MemReady);
endinterface

// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS control FSM with memory wait handshake and illegal-opcode pulse.
// Optional bne support is enabled by defining MIPS_MC_BNE_EN.
module mips_multicycle_control #(
  parameter int MEM_WAIT = 0,
  parameter int STATE_W  = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [5:0]                OpCode,
  mips_multicycle_control_if.master mem,
  output logic                      IRWrite,
  output logic                      PCWrite,
  output logic                      Branch,
  output logic                      BranchNe,
  output logic [1:0]                PCSrc,
  output logic                      ALUSrcA,
  output logic [1:0]                ALUSrcB,
  output logic [1:0]                ALUOp,
  output logic [1:0]                RegDst,
  output logic [1:0]                MemToReg,
  output logic                      RegWrite,
  output logic                      IllegalOp,
  output logic [STATE_W-1:0]        State
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
`ifdef MIPS_MC_BNE_EN
  localparam logic [5:0] OP_BNE   = 6'b000101;
`endif
  localparam logic [3:0] WAIT_INIT = 4'(MEM_WAIT);

  typedef enum logic [STATE_W-1:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXEC,
    S_ALUWB, S_BRANCH, S_ADDIEX, S_ADDIWB, S_JUMP, S_JAL
`ifdef MIPS_MC_BNE_EN
    , S_BRANCHNE
`endif
  } state_e;

  typedef struct packed {
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       pc_write;
    logic       branch;
`ifdef MIPS_MC_BNE_EN
    logic       branch_ne;
`endif
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       reg_write;
  } ctrl_t;

  // Moore output bundle for a state; anything not named stays 0.
  function automatic ctrl_t moore_ctrl(input state_e s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH:  begin c.mem_read = 1'b1; c.alu_src_b = 2'b01; end
      S_DECODE: c.alu_src_b = 2'b11;
      S_MEMADR: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
      S_MEMRD:  begin c.iord = 1'b1; c.mem_read = 1'b1; end
      S_MEMWB:  begin c.mem_to_reg = 2'b01; c.reg_write = 1'b1; end
      S_MEMWR:  begin c.iord = 1'b1; c.mem_write = 1'b1; end
      S_EXEC:   begin c.alu_src_a = 1'b1; c.alu_op = 2'b10; end
      S_ALUWB:  begin c.reg_dst = 2'b01; c.reg_write = 1'b1; end
      S_BRANCH: begin
        c.alu_src_a = 1'b1; c.alu_op = 2'b01; c.pc_src = 2'b01; c.branch = 1'b1;
      end
      S_ADDIEX: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
      S_ADDIWB: c.reg_write = 1'b1;
      S_JUMP:   begin c.pc_src = 2'b10; c.pc_write = 1'b1; end
      S_JAL:    begin
        c.pc_src = 2'b10; c.pc_write = 1'b1; c.reg_dst = 2'b10;
        c.mem_to_reg = 2'b10; c.reg_write = 1'b1;
      end
`ifdef MIPS_MC_BNE_EN
      S_BRANCHNE: begin
        c.alu_src_a = 1'b1; c.alu_op = 2'b01; c.pc_src = 2'b01; c.branch_ne = 1'b1;
      end
`endif
      default:  c = '0;
    endcase
    return c;
  endfunction

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  ctrl_t      ctrl_q;
  logic       illegal_s;
  logic       enter_s;
  logic       done_s;
  logic       fetch_done_s;

  assign done_s       = (cnt_q == 4'd0) && mem.MemReady;
  assign fetch_done_s = (state_q == S_FETCH) && done_s;

  // Next-state selection and illegal-opcode detection.
  always_comb begin
    state_d   = state_q;
    illegal_s = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (done_s) state_d = S_DECODE;
        else        state_d = S_FETCH;
      end
      S_DECODE: begin
        case (OpCode)
          OP_RTYPE:     state_d = S_EXEC;
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          OP_JAL:       state_d = S_JAL;
`ifdef MIPS_MC_BNE_EN
          OP_BNE:       state_d = S_BRANCHNE;
`endif
          default: begin
            state_d   = S_FETCH;
            illegal_s = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        if (OpCode == OP_SW) state_d = S_MEMWR;
        else                 state_d = S_MEMRD;
      end
      S_MEMRD: begin
        if (done_s) state_d = S_MEMWB;
        else        state_d = S_MEMRD;
      end
      S_MEMWR: begin
        if (done_s) state_d = S_FETCH;
        else        state_d = S_MEMWR;
      end
      S_EXEC:   state_d = S_ALUWB;
      S_ADDIEX: state_d = S_ADDIWB;
      default:  state_d = S_FETCH;
    endcase
  end

  // Wait counter reloads on entry to a memory state, else counts down to 0.
  always_comb begin
    enter_s = (state_d != state_q) && (state_d inside {S_FETCH, S_MEMRD, S_MEMWR});
    cnt_d   = cnt_q;
    if (enter_s)             cnt_d = WAIT_INIT;
    else if (cnt_q != 4'd0)  cnt_d = cnt_q - 4'd1;
    else                     cnt_d = cnt_q;
  end

  // State, wait counter and Moore outputs for the upcoming state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      cnt_q   <= WAIT_INIT;
      ctrl_q  <= moore_ctrl(S_FETCH);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ctrl_q  <= moore_ctrl(state_d);
    end
  end

  // Write strobes are forced low while reset is high so an abort writes nothing.
  assign mem.IorD     = ctrl_q.iord;
  assign mem.MemRead  = ctrl_q.mem_read;
  assign mem.MemWrite = ctrl_q.mem_write & ~reset;
  assign IRWrite      = fetch_done_s & ~reset;
  assign PCWrite      = (ctrl_q.pc_write | fetch_done_s) & ~reset;
  assign Branch       = ctrl_q.branch & ~reset;
`ifdef MIPS_MC_BNE_EN
  assign BranchNe     = ctrl_q.branch_ne & ~reset;
`else
  assign BranchNe     = 1'b0;
`endif
  assign PCSrc        = ctrl_q.pc_src;
  assign ALUSrcA      = ctrl_q.alu_src_a;
  assign ALUSrcB      = ctrl_q.alu_src_b;
  assign ALUOp        = ctrl_q.alu_op;
  assign RegDst       = ctrl_q.reg_dst;
  assign MemToReg     = ctrl_q.mem_to_reg;
  assign RegWrite     = ctrl_q.reg_write & ~reset;
  assign IllegalOp    = illegal_s & ~reset;
  assign State        = state_q;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Randomised bench for mips_multicycle_control: two instances (MEM_WAIT 0 and 2)
// checked cycle by cycle against a phase-list model of each instruction.
module tb_mips_multicycle_control;

  localparam int W0 = 0;
  localparam int W2 = 2;

  localparam int P_FETCH = 0, P_DECODE = 1, P_MEMADR = 2, P_MEMRD = 3, P_MEMWB = 4;
  localparam int P_MEMWR = 5, P_EXEC = 6, P_ALUWB = 7, P_BRANCH = 8, P_ADDIEX = 9;
  localparam int P_ADDIWB = 10, P_JUMP = 11, P_JAL = 12, P_BRANCHNE = 13;

  typedef struct packed {
    logic       iord, mem_read, mem_write, ir_write, pc_write, branch, branch_ne;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b, alu_op, reg_dst, mem_to_reg;
    logic       reg_write, illegal_op;
  } ctl_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst0, rst2;
  logic [5:0] op0, op2;
  int         n_checks = 0;
  int         n_fail   = 0;

  mips_multicycle_control_if if0 ();
  mips_multicycle_control_if if2 ();

  logic d0_irw, d0_pcw, d0_br, d0_brne, d0_alua, d0_rw, d0_ill;
  logic [1:0] d0_pcsrc, d0_alub, d0_aluop, d0_regdst, d0_m2r;
  logic [3:0] d0_st;
  logic d2_irw, d2_pcw, d2_br, d2_brne, d2_alua, d2_rw, d2_ill;
  logic [1:0] d2_pcsrc, d2_alub, d2_aluop, d2_regdst, d2_m2r;
  logic [3:0] d2_st;

  mips_multicycle_control #(.MEM_WAIT(W0), .STATE_W(4)) dut0 (
    .clk(clk), .reset(rst0), .OpCode(op0), .mem(if0.master),
    .IRWrite(d0_irw), .PCWrite(d0_pcw), .Branch(d0_br), .BranchNe(d0_brne),
    .PCSrc(d0_pcsrc), .ALUSrcA(d0_alua), .ALUSrcB(d0_alub), .ALUOp(d0_aluop),
    .RegDst(d0_regdst), .MemToReg(d0_m2r), .RegWrite(d0_rw), .IllegalOp(d0_ill),
    .State(d0_st)
  );

  mips_multicycle_control #(.MEM_WAIT(W2), .STATE_W(4)) dut2 (
    .clk(clk), .reset(rst2), .OpCode(op2), .mem(if2.master),
    .IRWrite(d2_irw), .PCWrite(d2_pcw), .Branch(d2_br), .BranchNe(d2_brne),
    .PCSrc(d2_pcsrc), .ALUSrcA(d2_alua), .ALUSrcB(d2_alub), .ALUOp(d2_aluop),
    .RegDst(d2_regdst), .MemToReg(d2_m2r), .RegWrite(d2_rw), .IllegalOp(d2_ill),
    .State(d2_st)
  );

  ctl_t obs0, obs2;
  assign obs0 = {if0.IorD, if0.MemRead, if0.MemWrite, d0_irw, d0_pcw, d0_br, d0_brne,
                 d0_pcsrc, d0_alua, d0_alub, d0_aluop, d0_regdst, d0_m2r, d0_rw, d0_ill};
  assign obs2 = {if2.IorD, if2.MemRead, if2.MemWrite, d2_irw, d2_pcw, d2_br, d2_brne,
                 d2_pcsrc, d2_alua, d2_alub, d2_aluop, d2_regdst, d2_m2r, d2_rw, d2_ill};

  function automatic ctl_t obs(input bit s);
    return s ? obs2 : obs0;
  endfunction

  function automatic int wait_of(input bit s);
    return s ? W2 : W0;
  endfunction

  function automatic bit is_legal(input logic [5:0] op);
    case (op)
      6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010, 6'b000011: return 1'b1;
`ifdef MIPS_MC_BNE_EN
      6'b000101: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

  // Expected control word for one phase of an instruction.
  function automatic ctl_t model_ctl(input int p, input logic [5:0] op, input bit dn);
    ctl_t m;
    m = '0;
    case (p)
      P_FETCH:    begin m.mem_read = 1'b1; m.alu_src_b = 2'b01; m.ir_write = dn; m.pc_write = dn; end
      P_DECODE:   begin m.alu_src_b = 2'b11; m.illegal_op = !is_legal(op); end
      P_MEMADR:   begin m.alu_src_a = 1'b1; m.alu_src_b = 2'b10; end
      P_MEMRD:    begin m.iord = 1'b1; m.mem_read = 1'b1; end
      P_MEMWB:    begin m.mem_to_reg = 2'b01; m.reg_write = 1'b1; end
      P_MEMWR:    begin m.iord = 1'b1; m.mem_write = 1'b1; end
      P_EXEC:     begin m.alu_src_a = 1'b1; m.alu_op = 2'b10; end
      P_ALUWB:    begin m.reg_dst = 2'b01; m.reg_write = 1'b1; end
      P_BRANCH:   begin m.alu_src_a = 1'b1; m.alu_op = 2'b01; m.pc_src = 2'b01; m.branch = 1'b1; end
      P_ADDIEX:   begin m.alu_src_a = 1'b1; m.alu_src_b = 2'b10; end
      P_ADDIWB:   m.reg_write = 1'b1;
      P_JUMP:     begin m.pc_src = 2'b10; m.pc_write = 1'b1; end
      P_JAL:      begin m.pc_src = 2'b10; m.pc_write = 1'b1; m.reg_dst = 2'b10;
                        m.mem_to_reg = 2'b10; m.reg_write = 1'b1; end
      P_BRANCHNE: begin m.alu_src_a = 1'b1; m.alu_op = 2'b01; m.pc_src = 2'b01; m.branch_ne = 1'b1; end
      default:    m = '0;
    endcase
    return m;
  endfunction

  task automatic tick(input bit s, input bit rdy, input bit rst, input logic [5:0] op);
    @(negedge clk);
    if (s) begin if2.MemReady = rdy; rst2 = rst; op2 = op; end
    else   begin if0.MemReady = rdy; rst0 = rst; op0 = op; end
    #1;
  endtask

  // Runs one instruction from its FETCH onward, checking every cycle.
  task automatic run_instr(input bit s, input logic [5:0] op, input int stall, input bit rnd,
                           input string tag, output int cycles, output int mw_cnt);
    int ph[$];
    logic [5:0] cur;
    ctl_t e, o;
    int k, left;
    bit rdy, dn, is_mem;
    ph.push_back(P_FETCH);
    ph.push_back(P_DECODE);
    case (op)
      6'b000000: begin ph.push_back(P_EXEC); ph.push_back(P_ALUWB); end
      6'b100011: begin ph.push_back(P_MEMADR); ph.push_back(P_MEMRD); ph.push_back(P_MEMWB); end
      6'b101011: begin ph.push_back(P_MEMADR); ph.push_back(P_MEMWR); end
      6'b000100: ph.push_back(P_BRANCH);
      6'b001000: begin ph.push_back(P_ADDIEX); ph.push_back(P_ADDIWB); end
      6'b000010: ph.push_back(P_JUMP);
      6'b000011: ph.push_back(P_JAL);
`ifdef MIPS_MC_BNE_EN
      6'b000101: ph.push_back(P_BRANCHNE);
`endif
      default: ;
    endcase
    cur = s ? op2 : op0;
    cycles = 0;
    mw_cnt = 0;
    foreach (ph[i]) begin
      k = 0;
      is_mem = (ph[i] == P_FETCH) || (ph[i] == P_MEMRD) || (ph[i] == P_MEMWR);
      left = (ph[i] == P_MEMRD || ph[i] == P_MEMWR) ? stall : 0;
      do begin
        if (left > 0) begin rdy = 1'b0; left--; end
        else if (rnd && k < 12) rdy = ($urandom_range(0, 3) != 0);
        else rdy = 1'b1;
        dn = is_mem && (k >= wait_of(s)) && rdy;
        if (ph[i] == P_FETCH && dn) cur = op;
        tick(s, rdy, 1'b0, cur);
        e = model_ctl(ph[i], cur, dn);
        o = obs(s);
        n_checks++;
        if (o !== e) begin
          n_fail++;
          $display("FAIL %s op=%b phase=%0d cycle=%0d: got %h expected %h", tag, op, ph[i], k, o, e);
        end
        if (o.mem_write === 1'b1) mw_cnt++;
        cycles++;
        k++;
      end while (is_mem && !dn);
    end
  endtask

  task automatic test_reset(input bit s);
    ctl_t o;
    for (int i = 0; i < 2; i++) begin
      tick(s, 1'b1, 1'b1, 6'b000000);
      o = obs(s);
      n_checks++;
      if ({o.ir_write, o.pc_write, o.mem_write, o.reg_write, o.branch, o.branch_ne} !== 6'b000000) begin
        n_fail++;
        $display("FAIL reset_strobes dut%0d: got %b required 000000", s,
                 {o.ir_write, o.pc_write, o.mem_write, o.reg_write, o.branch, o.branch_ne});
      end
    end
  endtask

  task automatic test_cycle_counts();
    logic [5:0] ops [7];
    int exp_c [7];
    int c, m;
    ops   = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010, 6'b000011};
    exp_c = '{4, 5, 4, 3, 4, 3, 3};
    for (int i = 0; i < 7; i++) begin
      run_instr(1'b0, ops[i], 0, 1'b0, "counts", c, m);
      n_checks++;
      if (c !== exp_c[i]) begin
        n_fail++;
        $display("FAIL cycle_count op=%b: got %0d required %0d", ops[i], c, exp_c[i]);
      end
    end
  endtask

  task automatic test_sw_stall();
    int c, m;
    run_instr(1'b0, 6'b101011, 4, 1'b0, "sw_stall", c, m);
    n_checks++;
    if (c !== 8) begin n_fail++; $display("FAIL sw_stall_cycles: got %0d required 8", c); end
    n_checks++;
    if (m !== 5) begin n_fail++; $display("FAIL sw_stall_memwrite: got %0d required 5", m); end
  endtask

  task automatic test_illegal();
    int c, m;
    run_instr(1'b0, 6'b111111, 0, 1'b0, "illegal", c, m);
    n_checks++;
    if (c !== 2) begin n_fail++; $display("FAIL illegal_cycles: got %0d required 2", c); end
    run_instr(1'b0, 6'b000101, 0, 1'b0, "bne", c, m);
    n_checks++;
`ifdef MIPS_MC_BNE_EN
    if (c !== 3) begin n_fail++; $display("FAIL bne_cycles: got %0d required 3", c); end
`else
    if (c !== 2) begin n_fail++; $display("FAIL bne_cycles: got %0d required 2", c); end
`endif
  endtask

  // Aborts a lw in MEMRD and a sw in MEMWR with reset, then expects a clean FETCH.
  task automatic test_reset_abort();
    logic [5:0] ops [2];
    ctl_t o;
    int c, m;
    ops = '{6'b100011, 6'b101011};
    for (int i = 0; i < 2; i++) begin
      tick(1'b0, 1'b1, 1'b0, ops[i]);
      tick(1'b0, 1'b1, 1'b0, ops[i]);
      tick(1'b0, 1'b1, 1'b0, ops[i]);
      tick(1'b0, (i == 0), 1'b1, ops[i]);
      o = obs(1'b0);
      n_checks++;
      if ({o.iord, o.mem_read, o.ir_write, o.pc_write, o.mem_write, o.reg_write, o.branch, o.branch_ne}
          !== {1'b1, (i == 0), 6'b000000}) begin
        n_fail++;
        $display("FAIL reset_abort_%0d: got %b required %b", i,
                 {o.iord, o.mem_read, o.ir_write, o.pc_write, o.mem_write, o.reg_write, o.branch, o.branch_ne},
                 {1'b1, (i == 0), 6'b000000});
      end
      run_instr(1'b0, 6'b000000, 0, 1'b0, "after_abort", c, m);
      n_checks++;
      if (c !== 4) begin n_fail++; $display("FAIL after_abort_cycles_%0d: got %0d required 4", i, c); end
    end
  endtask

  task automatic test_lw_wait();
    int c, m;
    run_instr(1'b1, 6'b100011, 0, 1'b0, "lw_wait", c, m);
    n_checks++;
    if (c !== 9) begin n_fail++; $display("FAIL lw_wait_cycles: got %0d required 9", c); end
    run_instr(1'b1, 6'b000000, 0, 1'b0, "rtype_wait", c, m);
    n_checks++;
    if (c !== 6) begin n_fail++; $display("FAIL rtype_wait_cycles: got %0d required 6", c); end
  endtask

  task automatic test_random(input bit s, input int n);
    logic [5:0] pool [8];
    logic [5:0] op;
    int c, m;
    pool = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010, 6'b000011, 6'b000101};
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 4) != 0) op = pool[$urandom_range(0, 7)];
      else op = 6'($urandom_range(0, 63));
      run_instr(s, op, $urandom_range(0, 3), 1'b1, "random", c, m);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst0 = 1'b1;
    rst2 = 1'b1;
    op0  = 6'b000000;
    op2  = 6'b000000;
    if0.MemReady = 1'b0;
    if2.MemReady = 1'b0;
    test_reset(1'b0);
    test_cycle_counts();
    test_sw_stall();
    test_illegal();
    test_reset_abort();
    test_random(1'b0, 60);
    test_reset(1'b1);
    test_lw_wait();
    test_random(1'b1, 60);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
